// File: rtl/regfile_wb_arbiter_if.sv
// Write-port arbiter bundle: producer A/B handshakes, decode issue/hazard
// signals and the registered register-file write port.
interface regfile_wb_arbiter_if;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_wn;
    logic [31:0] a_d;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_wn;
    logic [31:0] b_d;
    logic        iss_valid;
    logic [4:0]  iss_wn;
    logic        iss_stall;
    logic [4:0]  rna;
    logic [4:0]  rnb;
    logic        hz_a;
    logic        hz_b;
    logic [4:0]  wn;
    logic [31:0] d;
    logic        we;

    modport master (
        output a_valid, a_wn, a_d, b_valid, b_wn, b_d, iss_valid, iss_wn, rna, rnb,
        input  a_ready, b_ready, iss_stall, hz_a, hz_b, wn, d, we
    );

    modport slave (
        input  a_valid, a_wn, a_d, b_valid, b_wn, b_d, iss_valid, iss_wn, rna, rnb,
        output a_ready, b_ready, iss_stall, hz_a, hz_b, wn, d, we
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between writeback (A) and mul/div (B)
// with anti-starvation for B, and scoreboards destinations with pending writes.
module regfile_wb_arbiter #(
    parameter int unsigned STARVE_LIM = 4
) (
    input logic                  clk,
    input logic                  clr,
    regfile_wb_arbiter_if.slave  bus
);

    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    logic [3:0]  wcnt;
    logic        b_pri;
    logic [31:0] pend;
    logic [31:0] pend_nxt;
    logic        iss_set;

    assign b_pri       = (wcnt == LIM);
    assign bus.a_ready = bus.a_valid & ~b_pri;
    assign bus.b_ready = bus.b_valid & (b_pri | ~bus.a_valid);

    assign bus.iss_stall = bus.iss_valid & pend[bus.iss_wn];
    assign bus.hz_a      = pend[bus.rna];
    assign bus.hz_b      = pend[bus.rnb];
    assign iss_set       = bus.iss_valid & ~bus.iss_stall & (bus.iss_wn != 5'd0);

    always_ff @(posedge clk) begin
        if (clr) begin
            wcnt <= '0;
        end else if (bus.b_ready) begin
            wcnt <= '0;
        end else if (bus.b_valid && wcnt != LIM) begin
            wcnt <= wcnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            bus.we <= 1'b0;
            bus.wn <= '0;
            bus.d  <= '0;
        end else if (bus.a_ready) begin
            bus.we <= (bus.a_wn != 5'd0);
            bus.wn <= bus.a_wn;
            bus.d  <= bus.a_d;
        end else if (bus.b_ready) begin
            bus.we <= (bus.b_wn != 5'd0);
            bus.wn <= bus.b_wn;
            bus.d  <= bus.b_d;
        end else begin
            bus.we <= 1'b0;
        end
    end

    // Clear is applied before set so a same-cycle issue of the written register wins.
    always_comb begin
        pend_nxt = pend;
        if (bus.we) begin
            pend_nxt[bus.wn] = 1'b0;
        end
        if (iss_set) begin
            pend_nxt[bus.iss_wn] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: grant order, output timing,
// scoreboard set/clear/stall, r0 handling and mid-operation reset.
module tb_regfile_wb_arbiter;

    logic clk;
    logic clr;
    int   errors;
    int   checks;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.STARVE_LIM(4)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.a_valid   = 1'b0;
        bus.a_wn      = '0;
        bus.a_d       = '0;
        bus.b_valid   = 1'b0;
        bus.b_wn      = '0;
        bus.b_d       = '0;
        bus.iss_valid = 1'b0;
        bus.iss_wn    = '0;
        bus.rna       = '0;
        bus.rnb       = '0;
    endtask

    task automatic test_reset;
        idle_inputs();
        clr = 1'b1;
        tick();
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
        #1;
        checks++;
        if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: a_ready=%b b_ready=%b want 1 0", bus.a_ready, bus.b_ready);
        end
        tick();
        clr = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if (bus.we !== 1'b0 || bus.wn !== 5'd0 || bus.d !== 32'd0) begin
            errors++;
            $display("FAIL reset_out: we=%b wn=%0d d=%h want 0 0 0", bus.we, bus.wn, bus.d);
        end
        checks++;
        if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0 || bus.hz_a !== 1'b0 || bus.hz_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_comb: a_ready=%b b_ready=%b hz_a=%b hz_b=%b want 0", bus.a_ready, bus.b_ready, bus.hz_a, bus.hz_b);
        end
    endtask

    task automatic test_a_write;
        bus.a_valid = 1'b1;
        bus.a_wn    = 5'd5;
        bus.a_d     = 32'h1234_5678;
        #1;
        checks++;
        if (bus.a_ready !== 1'b1) begin
            errors++;
            $display("FAIL a_ready: got %b want 1", bus.a_ready);
        end
        tick();
        bus.a_valid = 1'b0;
        checks++;
        if (bus.we !== 1'b1 || bus.wn !== 5'd5 || bus.d !== 32'h1234_5678) begin
            errors++;
            $display("FAIL a_write_out: we=%b wn=%0d d=%h want 1 5 12345678", bus.we, bus.wn, bus.d);
        end
        tick();
        checks++;
        if (bus.we !== 1'b0 || bus.wn !== 5'd5 || bus.d !== 32'h1234_5678) begin
            errors++;
            $display("FAIL a_write_hold: we=%b wn=%0d d=%h want 0 5 12345678", bus.we, bus.wn, bus.d);
        end
    endtask

    task automatic test_starvation;
        logic exp_b;
        bus.a_valid = 1'b1;
        bus.a_wn    = 5'd1;
        bus.a_d     = 32'hAAAA_0001;
        bus.b_valid = 1'b1;
        bus.b_wn    = 5'd2;
        bus.b_d     = 32'hBBBB_0002;
        for (int i = 0; i < 10; i++) begin
            exp_b = ((i % 5) == 4);
            #1;
            checks++;
            if (bus.a_ready !== ~exp_b || bus.b_ready !== exp_b) begin
                errors++;
                $display("FAIL starve_grant[%0d]: a_ready=%b b_ready=%b want %b %b", i, bus.a_ready, bus.b_ready, ~exp_b, exp_b);
            end
            tick();
            checks++;
            if (bus.we !== 1'b1 || bus.wn !== (exp_b ? 5'd2 : 5'd1)) begin
                errors++;
                $display("FAIL starve_out[%0d]: we=%b wn=%0d want 1 %0d", i, bus.we, bus.wn, exp_b ? 2 : 1);
            end
        end
        // Counter is back at zero: A alone wins immediately, B alone is granted.
        bus.b_valid = 1'b0;
        #1;
        checks++;
        if (bus.a_ready !== 1'b1) begin
            errors++;
            $display("FAIL starve_wcnt0: a_ready=%b want 1", bus.a_ready);
        end
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b1;
        #1;
        checks++;
        if (bus.b_ready !== 1'b1 || bus.a_ready !== 1'b0) begin
            errors++;
            $display("FAIL b_alone: a_ready=%b b_ready=%b want 0 1", bus.a_ready, bus.b_ready);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_hazard;
        bus.iss_valid = 1'b1;
        bus.iss_wn    = 5'd7;
        bus.rna       = 5'd7;
        bus.rnb       = 5'd7;
        #1;
        checks++;
        if (bus.hz_a !== 1'b0 || bus.iss_stall !== 1'b0) begin
            errors++;
            $display("FAIL hz_same_cycle: hz_a=%b iss_stall=%b want 0 0", bus.hz_a, bus.iss_stall);
        end
        tick();
        bus.iss_valid = 1'b0;
        checks++;
        if (bus.hz_a !== 1'b1 || bus.hz_b !== 1'b1) begin
            errors++;
            $display("FAIL hz_set: hz_a=%b hz_b=%b want 1 1", bus.hz_a, bus.hz_b);
        end
        bus.iss_valid = 1'b1;
        #1;
        checks++;
        if (bus.iss_stall !== 1'b1) begin
            errors++;
            $display("FAIL waw_stall: iss_stall=%b want 1", bus.iss_stall);
        end
        tick();
        bus.iss_valid = 1'b0;
        bus.b_valid   = 1'b1;
        bus.b_wn      = 5'd7;
        bus.b_d       = 32'hCAFE_0007;
        #1;
        checks++;
        if (bus.hz_a !== 1'b1 || bus.b_ready !== 1'b1) begin
            errors++;
            $display("FAIL hz_hold: hz_a=%b b_ready=%b want 1 1", bus.hz_a, bus.b_ready);
        end
        tick();
        bus.b_valid = 1'b0;
        checks++;
        if (bus.we !== 1'b1 || bus.wn !== 5'd7 || bus.d !== 32'hCAFE_0007 || bus.hz_a !== 1'b1) begin
            errors++;
            $display("FAIL hz_we_cycle: we=%b wn=%0d d=%h hz_a=%b want 1 7 cafe0007 1", bus.we, bus.wn, bus.d, bus.hz_a);
        end
        tick();
        checks++;
        if (bus.hz_a !== 1'b0 || bus.hz_b !== 1'b0 || bus.we !== 1'b0) begin
            errors++;
            $display("FAIL hz_clear: hz_a=%b hz_b=%b we=%b want 0 0 0", bus.hz_a, bus.hz_b, bus.we);
        end
    endtask

    task automatic test_set_wins_and_r0;
        bus.a_valid = 1'b1;
        bus.a_wn    = 5'd9;
        bus.a_d     = 32'h0000_0099;
        tick();
        bus.a_valid   = 1'b0;
        bus.iss_valid = 1'b1;
        bus.iss_wn    = 5'd9;
        bus.rna       = 5'd9;
        #1;
        checks++;
        if (bus.we !== 1'b1 || bus.wn !== 5'd9 || bus.iss_stall !== 1'b0) begin
            errors++;
            $display("FAIL r9_we: we=%b wn=%0d iss_stall=%b want 1 9 0", bus.we, bus.wn, bus.iss_stall);
        end
        tick();
        bus.iss_valid = 1'b0;
        checks++;
        if (bus.hz_a !== 1'b1) begin
            errors++;
            $display("FAIL set_wins: hz_a=%b want 1", bus.hz_a);
        end
        bus.a_valid   = 1'b1;
        bus.a_wn      = 5'd0;
        bus.a_d       = 32'hDEAD_BEEF;
        bus.iss_valid = 1'b1;
        bus.iss_wn    = 5'd0;
        bus.rnb       = 5'd0;
        #1;
        checks++;
        if (bus.a_ready !== 1'b1 || bus.iss_stall !== 1'b0) begin
            errors++;
            $display("FAIL r0_accept: a_ready=%b iss_stall=%b want 1 0", bus.a_ready, bus.iss_stall);
        end
        tick();
        bus.a_valid   = 1'b0;
        bus.iss_valid = 1'b0;
        bus.rna       = 5'd0;
        #1;
        checks++;
        if (bus.we !== 1'b0 || bus.wn !== 5'd0 || bus.d !== 32'hDEAD_BEEF || bus.hz_a !== 1'b0 || bus.hz_b !== 1'b0) begin
            errors++;
            $display("FAIL r0_write: we=%b wn=%0d d=%h hz_a=%b hz_b=%b want 0 0 deadbeef 0 0", bus.we, bus.wn, bus.d, bus.hz_a, bus.hz_b);
        end
    endtask

    task automatic test_clr_mid;
        idle_inputs();
        bus.iss_valid = 1'b1;
        bus.iss_wn    = 5'd7;
        tick();
        bus.iss_wn = 5'd10;
        tick();
        bus.iss_valid = 1'b0;
        bus.rna       = 5'd7;
        bus.rnb       = 5'd10;
        #1;
        checks++;
        if (bus.hz_a !== 1'b1 || bus.hz_b !== 1'b1) begin
            errors++;
            $display("FAIL clr_pre: hz_a=%b hz_b=%b want 1 1", bus.hz_a, bus.hz_b);
        end
        bus.a_valid = 1'b1;
        bus.a_wn    = 5'd3;
        bus.a_d     = 32'h3333_3333;
        clr         = 1'b1;
        #1;
        checks++;
        if (bus.a_ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_grant: a_ready=%b want 1", bus.a_ready);
        end
        tick();
        clr         = 1'b0;
        bus.a_valid = 1'b0;
        bus.iss_valid = 1'b1;
        bus.iss_wn    = 5'd7;
        #1;
        checks++;
        if (bus.we !== 1'b0 || bus.wn !== 5'd0 || bus.d !== 32'd0) begin
            errors++;
            $display("FAIL clr_out: we=%b wn=%0d d=%h want 0 0 0", bus.we, bus.wn, bus.d);
        end
        checks++;
        if (bus.hz_a !== 1'b0 || bus.hz_b !== 1'b0 || bus.iss_stall !== 1'b0) begin
            errors++;
            $display("FAIL clr_pend: hz_a=%b hz_b=%b iss_stall=%b want 0 0 0", bus.hz_a, bus.hz_b, bus.iss_stall);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clr    = 1'b1;
        idle_inputs();
        test_reset();
        test_a_write();
        test_starvation();
        test_hazard();
        test_set_wins_and_r0();
        test_clr_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
